// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants, frame defaults and receiver FSM states.
// Also imported by the matching transmitter.
package uart_pkg;

  localparam int unsigned OS_RATE         = 16;
  localparam int unsigned MID_TICK        = OS_RATE / 2 - 1;
  localparam int unsigned DBIT_DEFAULT    = 8;
  localparam int unsigned SB_TICK_DEFAULT = 16;

  // Tick counter width; covers stop periods of up to 32 ticks.
  localparam int unsigned SCNT_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so that idle-high lines do not fake an edge out of reset.
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      q_o    <= ResetVal;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling: start bit, DBIT data bits LSB first, SB_TICK stop ticks.
// Emits a one-cycle rx_done_tick along with the received word and its stop-bit status.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = DBIT_DEFAULT,
  parameter int unsigned SB_TICK = SB_TICK_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            rx_busy
);

  localparam int unsigned NW = $clog2(DBIT);

  localparam logic [SCNT_W-1:0] MidCnt   = SCNT_W'(MID_TICK);
  localparam logic [SCNT_W-1:0] BitEnd   = SCNT_W'(OS_RATE - 1);
  localparam logic [SCNT_W-1:0] StopEnd  = SCNT_W'(SB_TICK - 1);
  localparam logic [NW-1:0]     LastBit  = NW'(DBIT - 1);

  logic rx_s;

  uart_rx_state_t    state_q;
  logic [SCNT_W-1:0] s_cnt_q;
  logic [NW-1:0]     n_cnt_q;
  logic [DBIT-1:0]   b_q;
  logic              stop_bad_q;
  logic [DBIT-1:0]   dout_q;
  logic              done_q;
  logic              frame_err_q;

  sync_2ff #(
    .ResetVal (1'b1)
  ) u_rx_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      b_q         <= '0;
      stop_bad_q  <= 1'b0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Start edge is taken on any clock, not only on s_tick.
          if (!rx_s) begin
            state_q <= StStart;
            s_cnt_q <= '0;
          end
        end
        StStart: begin
          if (s_tick) begin
            if (s_cnt_q == MidCnt) begin
              if (!rx_s) begin
                state_q <= StData;
                s_cnt_q <= '0;
                n_cnt_q <= '0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        StData: begin
          if (s_tick) begin
            if (s_cnt_q == BitEnd) begin
              s_cnt_q <= '0;
              b_q     <= {rx_s, b_q[DBIT-1:1]};
              if (n_cnt_q == LastBit) begin
                state_q <= StStop;
              end else begin
                n_cnt_q <= n_cnt_q + 1'b1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (s_tick) begin
            if (s_cnt_q == BitEnd) begin
              stop_bad_q <= ~rx_s;
            end
            if (s_cnt_q == StopEnd) begin
              state_q <= StIdle;
              s_cnt_q <= '0;
              dout_q  <= b_q;
              done_q  <= 1'b1;
              // With a single stop bit the mid-stop sample lands on this same tick.
              frame_err_q <= (s_cnt_q == BitEnd) ? ~rx_s : stop_bad_q;
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = frame_err_q;
  assign rx_busy      = (state_q != StIdle);

endmodule
